fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq_if.sv | 31 +++
 rtl/fp_mul_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand/result handshake bundle for the sequential FP multiplier.
// master drives operands and out_ready; slave (the multiplier) drives in_ready and results.
interface fp_mul_seq_if #(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   a_sign;
  logic                   b_sign;
  logic signed [NEXP+1:0] a_exp;
  logic signed [NEXP+1:0] b_exp;
  logic [NSIG:0]          a_sig;
  logic [NSIG:0]          b_sig;
  logic [5:0]             a_flags;
  logic [5:0]             b_flags;
  logic                   out_valid;
  logic                   out_ready;
  logic [NEXP+NSIG:0]     out_p;
  logic [3:0]             out_exc;

  modport master (
    output in_valid, a_sign, b_sign, a_exp, b_exp, a_sig, b_sig, a_flags, b_flags, out_ready,
    input  in_ready, out_valid, out_p, out_exc
  );

  modport slave (
    input  in_valid, a_sign, b_sign, a_exp, b_exp, a_sig, b_sig, a_flags, b_flags, out_ready,
    output in_ready, out_valid, out_p, out_exc
  );
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 multiplier, one multiplier bit per cycle (shift-add),
// followed by a single-cycle normalize / round-to-nearest-even / pack stage.
// Build option: define FP_MUL_SUBNORMAL_EN to denormalize tiny results; otherwise tiny
// results flush to signed zero.
module fp_mul_seq #(
  parameter int unsigned NEXP = 5,
  parameter int unsigned NSIG = 10
) (
  input logic         clk,
  input logic         rst,
  fp_mul_seq_if.slave bus
);

  localparam int unsigned ProdW = 2 * NSIG + 2;
  localparam int unsigned ExpW  = NEXP + 3;
  // One extra bit so normalization and rounding increments never wrap.
  localparam int unsigned NrmW  = ExpW + 1;
  localparam int unsigned OutW  = NEXP + NSIG + 1;
  localparam int unsigned CntW  = $clog2(NSIG + 1);
  localparam int          Bias  = (1 << (NEXP - 1)) - 1;

  localparam logic signed [NrmW-1:0] EMax = NrmW'(Bias);
  localparam logic signed [NrmW-1:0] EMin = NrmW'(1 - Bias);
  localparam logic signed [NrmW-1:0] EBias = NrmW'(Bias);
  localparam logic signed [NrmW-1:0] EOne = NrmW'(1);

  localparam int unsigned FlagSnan = 5;
  localparam int unsigned FlagQnan = 4;
  localparam int unsigned FlagInf  = 3;
  localparam int unsigned FlagZero = 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StNorm = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [OutW-1:0] QNaN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG - 1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic                   sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic signed [NEXP+1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [5:0]             flags_a_q, flags_a_d, flags_b_q, flags_b_d;
  logic [ProdW-1:0]       mcand_q, mcand_d, prod_q, prod_d;
  logic [NSIG:0]          mplier_q, mplier_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   wait_q, wait_d;
  logic [OutW-1:0]        out_p_q, out_p_d;
  logic [3:0]             out_exc_q, out_exc_d;

  logic            in_special;
  logic            nan_any, snan_any, inf_any, zero_any, inf_zero, sign_r;
  logic [OutW-1:0] res_p;
  logic [3:0]      res_exc;

  logic signed [ExpW-1:0] e_sum;
  logic signed [NrmW-1:0] e_norm, e_rnd, e_biased;
  logic [ProdW-1:0]       n, shifted;
  logic [NSIG:0]          sig, sig_fin;
  logic [NSIG+1:0]        sig_rnd;
  logic                   lost, tiny, guard, sticky, round_up, carry, inexact;
`ifdef FP_MUL_SUBNORMAL_EN
  logic [NrmW-1:0]        sh;
`endif

  logic unused_bits;
  assign unused_bits = ^{flags_a_q[1:0], flags_b_q[1:0], e_biased[NrmW-1:NEXP], sig_fin[NSIG]};

  assign in_special = |{bus.a_flags[FlagSnan:FlagZero], bus.b_flags[FlagSnan:FlagZero]};

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_p     = out_p_q;
  assign bus.out_exc   = out_exc_q;

  // Operand classification for the special-value bypass.
  always_comb begin
    snan_any = flags_a_q[FlagSnan] | flags_b_q[FlagSnan];
    nan_any  = snan_any | flags_a_q[FlagQnan] | flags_b_q[FlagQnan];
    inf_any  = flags_a_q[FlagInf] | flags_b_q[FlagInf];
    zero_any = flags_a_q[FlagZero] | flags_b_q[FlagZero];
    inf_zero = (flags_a_q[FlagInf] & flags_b_q[FlagZero]) |
               (flags_a_q[FlagZero] & flags_b_q[FlagInf]);
    sign_r   = sign_a_q ^ sign_b_q;
  end

  // Normalize, optionally denormalize, round to nearest-even and pick the packed result.
  always_comb begin
    e_sum  = $signed({exp_a_q[NEXP+1], exp_a_q}) + $signed({exp_b_q[NEXP+1], exp_b_q});
    n      = prod_q[ProdW-1] ? prod_q : (prod_q << 1);
    e_norm = $signed({e_sum[ExpW-1], e_sum}) + (prod_q[ProdW-1] ? EOne : '0);
    tiny   = (e_norm < EMin);
`ifdef FP_MUL_SUBNORMAL_EN
    sh      = tiny ? NrmW'(EMin - e_norm) : '0;
    shifted = n >> sh;
    // Anything shifted past the bottom only matters as sticky.
    lost    = ((shifted << sh) != n);
`else
    shifted = n;
    lost    = 1'b0;
`endif
    sig      = shifted[ProdW-1 -: NSIG+1];
    guard    = shifted[NSIG];
    sticky   = (|shifted[NSIG-1:0]) | lost;
    round_up = guard & (sticky | sig[0]);
    sig_rnd  = {1'b0, sig} + {{(NSIG + 1){1'b0}}, round_up};
    carry    = sig_rnd[NSIG+1];
    sig_fin  = carry ? sig_rnd[NSIG+1:1] : sig_rnd[NSIG:0];
    e_rnd    = carry ? e_norm + EOne : e_norm;
    e_biased = e_rnd + EBias;
    inexact  = guard | sticky;

    res_p   = '0;
    res_exc = '0;
    if (nan_any || inf_zero) begin
      res_p   = QNaN;
      res_exc = {snan_any | inf_zero, 3'b000};
    end else if (inf_any) begin
      res_p = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end else if (zero_any) begin
      res_p = {sign_r, {(OutW - 1){1'b0}}};
    end else if (tiny) begin
`ifdef FP_MUL_SUBNORMAL_EN
      // A round-up into the hidden bit lands exactly on the minimum normal (exp field 1).
      res_p   = {sign_r, {(NEXP - 1){1'b0}}, sig_fin[NSIG], sig_fin[NSIG-1:0]};
      res_exc = {2'b00, inexact, inexact};
`else
      res_p   = {sign_r, {(OutW - 1){1'b0}}};
      res_exc = 4'b0011;
`endif
    end else if (e_rnd > EMax) begin
      res_p   = {sign_r, {NEXP{1'b1}}, {NSIG{1'b0}}};
      res_exc = 4'b0101;
    end else begin
      res_p   = {sign_r, e_biased[NEXP-1:0], sig_fin[NSIG-1:0]};
      res_exc = {3'b000, inexact};
    end
  end

  // FSM next state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
    flags_a_d = flags_a_q;
    flags_b_d = flags_b_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    out_p_d   = out_p_q;
    out_exc_d = out_exc_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sign_a_d  = bus.a_sign;
          sign_b_d  = bus.b_sign;
          exp_a_d   = bus.a_exp;
          exp_b_d   = bus.b_exp;
          flags_a_d = bus.a_flags;
          flags_b_d = bus.b_flags;
          mcand_d   = {{(ProdW - NSIG - 1){1'b0}}, bus.a_sig};
          mplier_d  = bus.b_sig;
          prod_d    = '0;
          cnt_d     = '0;
          // Specials idle one cycle in NORM so they complete on the second edge.
          wait_d    = in_special;
          state_d   = in_special ? StNorm : StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NSIG)) state_d = StNorm;
      end
      StNorm: begin
        if (wait_q) begin
          wait_d = 1'b0;
        end else begin
          out_p_d   = res_p;
          out_exc_d = res_exc;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      exp_a_q   <= '0;
      exp_b_q   <= '0;
      flags_a_q <= '0;
      flags_b_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      wait_q    <= 1'b0;
      out_p_q   <= '0;
      out_exc_q <= '0;
    end else begin
      state_q   <= state_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      exp_a_q   <= exp_a_d;
      exp_b_q   <= exp_b_d;
      flags_a_q <= flags_a_d;
      flags_b_q <= flags_b_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      out_p_q   <= out_p_d;
      out_exc_q <= out_exc_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed self-checking bench for fp_mul_seq (NEXP=5, NSIG=10, half precision).
module tb_fp_mul_seq;

  localparam logic [5:0] FN = 6'b000001;
  localparam logic [5:0] FZ = 6'b000100;
  localparam logic [5:0] FI = 6'b001000;
  localparam logic [5:0] FQ = 6'b010000;
  localparam logic [5:0] FS = 6'b100000;

`ifdef FP_MUL_SUBNORMAL_EN
  localparam logic [15:0] TinyP    = 16'h0200;
  localparam logic [3:0]  TinyE    = 4'h0;
  localparam logic [15:0] TinyNegP = 16'h8200;
  localparam logic [15:0] TinyInxP = 16'h0200;
`else
  localparam logic [15:0] TinyP    = 16'h0000;
  localparam logic [3:0]  TinyE    = 4'h3;
  localparam logic [15:0] TinyNegP = 16'h8000;
  localparam logic [15:0] TinyInxP = 16'h0000;
`endif

  typedef struct {
    logic        as;
    int          ae;
    logic [10:0] asg;
    logic [5:0]  af;
    logic        bs;
    int          be;
    logic [10:0] bsg;
    logic [5:0]  bf;
    logic [15:0] p;
    logic [3:0]  exc;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fp_mul_seq_if #(.NEXP(5), .NSIG(10)) bus ();

  fp_mul_seq #(.NEXP(5), .NSIG(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    bus.a_sign  = v.as;
    bus.a_exp   = 7'(v.ae);
    bus.a_sig   = v.asg;
    bus.a_flags = v.af;
    bus.b_sign  = v.bs;
    bus.b_exp   = 7'(v.be);
    bus.b_sig   = v.bsg;
    bus.b_flags = v.bf;
  endtask

  // Offer one operand pair, wait (bounded) for the result, then let out_ready retire it.
  task automatic do_op(input vec_t v, output logic [15:0] p, output logic [3:0] e, output int lat);
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus.out_p;
    e = bus.out_exc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vec_t v;
    v = '{1'b0, 0, 11'h600, FN, 1'b0, 1, 11'h400, FN, 16'h0, 4'h0, 0};
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== 16'h0 ||
        bus.out_exc !== 4'h0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_p=%h out_exc=%h want 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_p, bus.out_exc);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_round();
    vec_t q[$];
    logic [15:0] p;
    logic [3:0]  e;
    int          lat;
    q.push_back('{1'b0, 0, 11'h600, FN, 1'b0, 1, 11'h400, FN, 16'h4200, 4'h0, 12});
    q.push_back('{1'b1, 0, 11'h600, FN, 1'b0, 1, 11'h400, FN, 16'hC200, 4'h0, 12});
    q.push_back('{1'b0, 0, 11'h401, FN, 1'b0, 0, 11'h401, FN, 16'h3C02, 4'h1, 12});
    q.push_back('{1'b0, 0, 11'h401, FN, 1'b0, 0, 11'h600, FN, 16'h3E02, 4'h1, 12});
    q.push_back('{1'b0, 0, 11'h403, FN, 1'b0, 0, 11'h600, FN, 16'h3E04, 4'h1, 12});
    q.push_back('{1'b0, 0, 11'h5A8, FN, 1'b0, 0, 11'h5A8, FN, 16'h4000, 4'h1, 12});
    q.push_back('{1'b0, 0, 11'h7FF, FN, 1'b1, 0, 11'h7FF, FN, 16'hC3FE, 4'h1, 12});
    q.push_back('{1'b0, -14, 11'h400, FN, 1'b0, 0, 11'h400, FN, 16'h0400, 4'h0, 12});
    foreach (q[i]) begin
      do_op(q[i], p, e, lat);
      checks++;
      if (p !== q[i].p || e !== q[i].exc || lat !== q[i].lat) begin
        errors++;
        $display("FAIL mul_round[%0d]: p=%h exc=%h lat=%0d want p=%h exc=%h lat=%0d",
                 i, p, e, lat, q[i].p, q[i].exc, q[i].lat);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t q[$];
    logic [15:0] p;
    logic [3:0]  e;
    int          lat;
    q.push_back('{1'b0, 15, 11'h400, FN, 1'b0, 0, 11'h400, FN, 16'h7800, 4'h0, 12});
    q.push_back('{1'b0, 15, 11'h400, FN, 1'b0, 1, 11'h400, FN, 16'h7C00, 4'h5, 12});
    q.push_back('{1'b1, 15, 11'h400, FN, 1'b0, 1, 11'h400, FN, 16'hFC00, 4'h5, 12});
    q.push_back('{1'b0, 15, 11'h5A8, FN, 1'b0, 0, 11'h5A8, FN, 16'h7C00, 4'h5, 12});
    foreach (q[i]) begin
      do_op(q[i], p, e, lat);
      checks++;
      if (p !== q[i].p || e !== q[i].exc || lat !== q[i].lat) begin
        errors++;
        $display("FAIL overflow[%0d]: p=%h exc=%h lat=%0d want p=%h exc=%h lat=%0d",
                 i, p, e, lat, q[i].p, q[i].exc, q[i].lat);
      end
    end
  endtask

  task automatic test_tiny();
    vec_t q[$];
    logic [15:0] p;
    logic [3:0]  e;
    int          lat;
    q.push_back('{1'b0, -14, 11'h400, FN, 1'b0, -1, 11'h400, FN, TinyP, TinyE, 12});
    q.push_back('{1'b1, -14, 11'h400, FN, 1'b0, -1, 11'h400, FN, TinyNegP, TinyE, 12});
    q.push_back('{1'b0, -14, 11'h400, FN, 1'b0, -1, 11'h401, FN, TinyInxP, 4'h3, 12});
    q.push_back('{1'b0, -20, 11'h400, FN, 1'b0, -20, 11'h400, FN, 16'h0000, 4'h3, 12});
    foreach (q[i]) begin
      do_op(q[i], p, e, lat);
      checks++;
      if (p !== q[i].p || e !== q[i].exc || lat !== q[i].lat) begin
        errors++;
        $display("FAIL tiny[%0d]: p=%h exc=%h lat=%0d want p=%h exc=%h lat=%0d",
                 i, p, e, lat, q[i].p, q[i].exc, q[i].lat);
      end
    end
  endtask

  task automatic test_specials();
    vec_t q[$];
    logic [15:0] p;
    logic [3:0]  e;
    int          lat;
    q.push_back('{1'b0, 0, 11'h400, FI, 1'b0, 0, 11'h000, FZ, 16'h7E00, 4'h8, 2});
    q.push_back('{1'b1, 0, 11'h000, FZ, 1'b0, 0, 11'h400, FI, 16'h7E00, 4'h8, 2});
    q.push_back('{1'b0, 0, 11'h600, FQ, 1'b0, 0, 11'h400, FN, 16'h7E00, 4'h0, 2});
    q.push_back('{1'b0, 0, 11'h400, FN, 1'b1, 0, 11'h500, FS, 16'h7E00, 4'h8, 2});
    q.push_back('{1'b0, 0, 11'h600, FQ, 1'b0, 0, 11'h000, FZ, 16'h7E00, 4'h0, 2});
    q.push_back('{1'b1, 0, 11'h400, FI, 1'b0, 3, 11'h600, FN, 16'hFC00, 4'h0, 2});
    q.push_back('{1'b1, 0, 11'h400, FI, 1'b1, 0, 11'h400, FI, 16'h7C00, 4'h0, 2});
    q.push_back('{1'b0, 0, 11'h000, FZ, 1'b1, 5, 11'h600, FN, 16'h8000, 4'h0, 2});
    foreach (q[i]) begin
      do_op(q[i], p, e, lat);
      checks++;
      if (p !== q[i].p || e !== q[i].exc || lat !== q[i].lat) begin
        errors++;
        $display("FAIL specials[%0d]: p=%h exc=%h lat=%0d want p=%h exc=%h lat=%0d",
                 i, p, e, lat, q[i].p, q[i].exc, q[i].lat);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    int   lat;
    v = '{1'b0, 0, 11'h600, FN, 1'b0, 1, 11'h400, FN, 16'h4200, 4'h0, 12};
    bus.out_ready = 1'b0;
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep offering a different pair while busy; it must be ignored.
    bus.a_flags = FZ;
    bus.a_sig   = 11'h7FF;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 12 || bus.out_p !== 16'h4200 || bus.out_exc !== 4'h0) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d p=%h exc=%h want lat=12 p=4200 exc=0",
               lat, bus.out_p, bus.out_exc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_p !== 16'h4200 ||
          bus.out_exc !== 4'h0) begin
        errors++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b p=%h exc=%h want 1 0 4200 0",
                 i, bus.out_valid, bus.in_ready, bus.out_p, bus.out_exc);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    vec_t        v;
    logic [15:0] p;
    logic [3:0]  e;
    int          lat;
    int          highs;
    v = '{1'b0, 0, 11'h600, FN, 1'b0, 1, 11'h400, FN, 16'h4200, 4'h0, 12};
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_in_mul: in_ready=%b want 0", bus.in_ready);
    end
    rst = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== 16'h0 ||
        bus.out_exc !== 4'h0) begin
      errors++;
      $display("FAIL mid_mul_reset: in_ready=%b out_valid=%b p=%h exc=%h want 1 0 0000 0",
               bus.in_ready, bus.out_valid, bus.out_p, bus.out_exc);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++;
      $display("FAIL aborted_no_output: out_valid high cycles=%0d want 0", highs);
    end
    do_op(v, p, e, lat);
    checks++;
    if (p !== 16'h4200 || e !== 4'h0 || lat !== 12) begin
      errors++;
      $display("FAIL after_reset_op: p=%h exc=%h lat=%0d want p=4200 exc=0 lat=12", p, e, lat);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_sign    = 1'b0;
    bus.b_sign    = 1'b0;
    bus.a_exp     = '0;
    bus.b_exp     = '0;
    bus.a_sig     = '0;
    bus.b_sig     = '0;
    bus.a_flags   = '0;
    bus.b_flags   = '0;
    test_reset();
    test_mul_round();
    test_overflow();
    test_tiny();
    test_specials();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
